// File: rtl/pcm_pkg.sv
// pcm_pkg: shared definitions for the PCM playback controller.
//   - pcm_state_e : playback sequencer states
//   - SAMPLE_W, CNT_W, RATE_W : default datapath widths
//   - MIN_DIV : smallest timer terminal count (minimum period = MIN_DIV+1 clocks)
//   - pcm_scale : signed volume scaling helper (volume build only)
// Optional feature macro: PCM_VOLUME_EN (adds the SCALE state and per-channel volume).
package pcm_pkg;

  localparam int SAMPLE_W = 16;
  localparam int CNT_W    = 10;
  localparam int RATE_W   = 16;

`ifdef PCM_VOLUME_EN
  // The extra SCALE stage pushes output latency out by one clock, so the
  // shortest legal period grows by one as well.
  localparam int MIN_DIV = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    POP   = 3'd2,
    LATCH = 3'd3,
    SCALE = 3'd4
  } pcm_state_e;

  // (sample * vol) >>> 8 with sample signed and vol unsigned 0..255.
  // The result always fits back into SAMPLE_W bits because vol < 256.
  function automatic logic [SAMPLE_W-1:0] pcm_scale(input logic [SAMPLE_W-1:0] sample,
                                                    input logic [7:0]          vol);
    logic signed [SAMPLE_W+8:0] prod;
    prod = $signed(sample) * $signed({1'b0, vol});
    return prod[SAMPLE_W+7:8];
  endfunction
`else
  localparam int MIN_DIV = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    POP   = 2'd2,
    LATCH = 2'd3
  } pcm_state_e;
`endif

endpackage

// File: rtl/pcm_rate_timer.sv
// pcm_rate_timer: programmable sample-rate divider.
//   Counts 0..term while enable is high and raises tick (combinational) on the
//   terminal count, then reloads 0. Held at 0 while enable is low.
//   term = max(rate_div, MIN_DIV); a new rate_div is picked up only when the
//   counter wraps (or while disabled), so a change never restarts a period.
// Ports:
//   clk      in  1       system clock
//   reset    in  1       asynchronous, active-high
//   enable   in  1       run the divider
//   rate_div in  RATE_W  requested period minus one
//   tick     out 1       high during the terminal-count cycle
module pcm_rate_timer #(
  parameter int RATE_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [RATE_W-1:0] rate_div,
  output logic              tick
);
  import pcm_pkg::*;

  localparam logic [RATE_W-1:0] MIN_DIV_W = RATE_W'(MIN_DIV);

  logic [RATE_W-1:0] cnt_r;
  logic [RATE_W-1:0] term_r;
  logic [RATE_W-1:0] clamp_s;

  // Clamp short periods so a fetch always completes before the next tick.
  always_comb begin
    clamp_s = rate_div;
    if (rate_div < MIN_DIV_W) begin
      clamp_s = MIN_DIV_W;
    end else begin
      clamp_s = rate_div;
    end
  end

  assign tick = enable && (cnt_r == term_r);

  // Counter and latched terminal count; term only reloads at a wrap or while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r  <= {RATE_W{1'b0}};
      term_r <= MIN_DIV_W;
    end else if (!enable) begin
      cnt_r  <= {RATE_W{1'b0}};
      term_r <= clamp_s;
    end else if (cnt_r == term_r) begin
      cnt_r  <= {RATE_W{1'b0}};
      term_r <= clamp_s;
    end else begin
      cnt_r  <= cnt_r + {{(RATE_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/pcm_playback_ctrl.sv
// pcm_playback_ctrl: sequences playback from the PCM sample FIFO to the mixer.
//   A rate timer ticks once per sample period; on each tick one stereo word
//   (L=[31:16], R=[15:0]) is popped and held on pcm_l/pcm_r. A tick with the
//   FIFO empty flags underrun and drives silence. A low-water IRQ asks the CPU
//   to refill. Timing: tick T -> fifo_rd_en T+1 -> data T+2 -> outputs T+3.
// Optional feature macro: PCM_VOLUME_EN adds vol_l/vol_r and a SCALE stage
//   (outputs at T+4, minimum period 5 clocks).
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   enable                playback enable
//   rate_div              sample period minus one (clamped to MIN_DIV)
//   irq_thresh            low-water threshold (0 disables the IRQ)
//   irq_clear             pulse: clear irq_pending
//   underrun_clr          pulse: clear underrun
//   fifo_rddata           FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty            FIFO empty
//   fifo_count            FIFO occupancy
//   vol_l, vol_r          channel volume (PCM_VOLUME_EN only)
//   fifo_rd_en            registered 1-cycle pop request
//   pcm_l, pcm_r          signed samples to the mixer
//   sample_strobe         1-cycle pulse when pcm_l/pcm_r update
//   irq_pending           sticky low-water interrupt
//   underrun              sticky underrun flag
module pcm_playback_ctrl #(
  parameter int RATE_W   = 16,
  parameter int CNT_W    = 10,
  parameter int SAMPLE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [RATE_W-1:0]     rate_div,
  input  logic [CNT_W-1:0]      irq_thresh,
  input  logic                  irq_clear,
  input  logic                  underrun_clr,
  input  logic [2*SAMPLE_W-1:0] fifo_rddata,
  input  logic                  fifo_empty,
  input  logic [CNT_W-1:0]      fifo_count,
`ifdef PCM_VOLUME_EN
  input  logic [7:0]            vol_l,
  input  logic [7:0]            vol_r,
`endif
  output logic                  fifo_rd_en,
  output logic [SAMPLE_W-1:0]   pcm_l,
  output logic [SAMPLE_W-1:0]   pcm_r,
  output logic                  sample_strobe,
  output logic                  irq_pending,
  output logic                  underrun
);
  import pcm_pkg::*;

  pcm_state_e state_r;
  pcm_state_e state_s;

  logic                tick_s;
  logic                pop_req_s;
  logic                underrun_set_s;
  logic                irq_set_s;

  logic                rd_en_r;
  logic [SAMPLE_W-1:0] pcm_l_r;
  logic [SAMPLE_W-1:0] pcm_r_r;
  logic                strobe_r;
  logic                irq_r;
  logic                underrun_r;

`ifdef PCM_VOLUME_EN
  logic [SAMPLE_W-1:0] raw_l_r;
  logic [SAMPLE_W-1:0] raw_r_r;
`endif

  pcm_rate_timer #(
    .RATE_W (RATE_W)
  ) u_rate_timer (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .rate_div (rate_div),
    .tick     (tick_s)
  );

  // Next-state logic; pop/underrun decisions use fifo_empty as seen at the tick.
  always_comb begin
    state_s        = state_r;
    pop_req_s      = 1'b0;
    underrun_set_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable) begin
          state_s = WAIT;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (!enable) begin
          state_s = IDLE;
        end else if (tick_s && !fifo_empty) begin
          state_s   = POP;
          pop_req_s = 1'b1;
        end else if (tick_s) begin
          state_s        = WAIT;
          underrun_set_s = 1'b1;
        end else begin
          state_s = WAIT;
        end
      end
      // A pop in flight always completes so the word is never dropped.
      POP: begin
        state_s = LATCH;
      end
`ifdef PCM_VOLUME_EN
      LATCH: begin
        state_s = SCALE;
      end
      SCALE: begin
        if (enable) begin
          state_s = WAIT;
        end else begin
          state_s = IDLE;
        end
      end
`else
      LATCH: begin
        if (enable) begin
          state_s = WAIT;
        end else begin
          state_s = IDLE;
        end
      end
`endif
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Pop request and sample output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_en_r  <= 1'b0;
      pcm_l_r  <= {SAMPLE_W{1'b0}};
      pcm_r_r  <= {SAMPLE_W{1'b0}};
      strobe_r <= 1'b0;
    end else begin
      rd_en_r  <= pop_req_s;
      strobe_r <= 1'b0;
      if (state_r == IDLE) begin
        pcm_l_r <= {SAMPLE_W{1'b0}};
        pcm_r_r <= {SAMPLE_W{1'b0}};
      end else if (underrun_set_s) begin
        pcm_l_r  <= {SAMPLE_W{1'b0}};
        pcm_r_r  <= {SAMPLE_W{1'b0}};
        strobe_r <= 1'b1;
`ifdef PCM_VOLUME_EN
      end else if (state_r == SCALE) begin
        pcm_l_r  <= pcm_scale(raw_l_r, vol_l);
        pcm_r_r  <= pcm_scale(raw_r_r, vol_r);
        strobe_r <= 1'b1;
`else
      end else if (state_r == LATCH) begin
        pcm_l_r  <= fifo_rddata[2*SAMPLE_W-1:SAMPLE_W];
        pcm_r_r  <= fifo_rddata[SAMPLE_W-1:0];
        strobe_r <= 1'b1;
`endif
      end else begin
        pcm_l_r <= pcm_l_r;
        pcm_r_r <= pcm_r_r;
      end
    end
  end

`ifdef PCM_VOLUME_EN
  // Raw word capture ahead of the scaling stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raw_l_r <= {SAMPLE_W{1'b0}};
      raw_r_r <= {SAMPLE_W{1'b0}};
    end else if (state_r == LATCH) begin
      raw_l_r <= fifo_rddata[2*SAMPLE_W-1:SAMPLE_W];
      raw_r_r <= fifo_rddata[SAMPLE_W-1:0];
    end else begin
      raw_l_r <= raw_l_r;
      raw_r_r <= raw_r_r;
    end
  end
`endif

  // Low-water condition; a zero threshold never fires.
  always_comb begin
    irq_set_s = 1'b0;
    if (enable && (irq_thresh != {CNT_W{1'b0}}) && (fifo_count < irq_thresh)) begin
      irq_set_s = 1'b1;
    end else begin
      irq_set_s = 1'b0;
    end
  end

  // Sticky flags; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_r      <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      if (irq_set_s) begin
        irq_r <= 1'b1;
      end else if (irq_clear) begin
        irq_r <= 1'b0;
      end else begin
        irq_r <= irq_r;
      end
      if (underrun_set_s) begin
        underrun_r <= 1'b1;
      end else if (underrun_clr) begin
        underrun_r <= 1'b0;
      end else begin
        underrun_r <= underrun_r;
      end
    end
  end

  assign fifo_rd_en    = rd_en_r;
  assign pcm_l         = pcm_l_r;
  assign pcm_r         = pcm_r_r;
  assign sample_strobe = strobe_r;
  assign irq_pending   = irq_r;
  assign underrun      = underrun_r;

endmodule

// File: tb/tb_pcm_playback_ctrl.sv
// Directed bench for pcm_playback_ctrl with a small FIFO model and an event
// recorder; expected values are hand-derived from the stated latencies.
module tb_pcm_playback_ctrl;
  localparam int RATE_W   = 16;
  localparam int CNT_W    = 10;
  localparam int SAMPLE_W = 16;
`ifdef PCM_VOLUME_EN
  localparam int LAT        = 3;
  localparam int MIN_PERIOD = 5;
`else
  localparam int LAT        = 2;
  localparam int MIN_PERIOD = 4;
`endif

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  enable;
  logic [RATE_W-1:0]     rate_div;
  logic [CNT_W-1:0]      irq_thresh;
  logic                  irq_clear;
  logic                  underrun_clr;
  logic [2*SAMPLE_W-1:0] fifo_rddata = 32'h0;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [7:0]            vol_l = 8'd128;
  logic [7:0]            vol_r = 8'd0;
  logic                  fifo_rd_en;
  logic [SAMPLE_W-1:0]   pcm_l;
  logic [SAMPLE_W-1:0]   pcm_r;
  logic                  sample_strobe;
  logic                  irq_pending;
  logic                  underrun;

  always #5 clk = ~clk;

  pcm_playback_ctrl #(.RATE_W(RATE_W), .CNT_W(CNT_W), .SAMPLE_W(SAMPLE_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .rate_div      (rate_div),
    .irq_thresh    (irq_thresh),
    .irq_clear     (irq_clear),
    .underrun_clr  (underrun_clr),
    .fifo_rddata   (fifo_rddata),
    .fifo_empty    (fifo_empty),
    .fifo_count    (fifo_count),
`ifdef PCM_VOLUME_EN
    .vol_l         (vol_l),
    .vol_r         (vol_r),
`endif
    .fifo_rd_en    (fifo_rd_en),
    .pcm_l         (pcm_l),
    .pcm_r         (pcm_r),
    .sample_strobe (sample_strobe),
    .irq_pending   (irq_pending),
    .underrun      (underrun)
  );

  // FIFO model: data appears the cycle after a pop request.
  logic [31:0]      fifo_mem [0:63];
  int               wr_ptr = 0;
  int               rd_ptr = 0;
  logic             cnt_ovr_en = 1'b0;
  logic [CNT_W-1:0] cnt_ovr = '0;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_count = cnt_ovr_en ? cnt_ovr : CNT_W'(wr_ptr - rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && (wr_ptr != rd_ptr)) begin
      fifo_rddata <= fifo_mem[rd_ptr % 64];
      rd_ptr      <= rd_ptr + 1;
    end
  end

  // Event recorder.
  int          cyc = 0;
  int          rd_q[$];
  int          st_cyc[$];
  logic [15:0] st_l[$];
  logic [15:0] st_r[$];
  logic        st_u[$];
  int          bad_pop = 0;
  int          b2b = 0;
  logic        prev_rd = 1'b0;

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      rd_q.push_back(cyc);
      if (fifo_empty) bad_pop++;
      if (prev_rd) b2b++;
    end
    prev_rd = fifo_rd_en;
    if (sample_strobe) begin
      st_cyc.push_back(cyc);
      st_l.push_back(pcm_l);
      st_r.push_back(pcm_r);
      st_u.push_back(underrun);
    end
    cyc++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_l(input logic [31:0] w);
`ifdef PCM_VOLUME_EN
    logic signed [15:0] s;
    logic signed [31:0] p;
    s = w[31:16];
    p = s * 32'sd128;
    p = p >>> 8;
    return p[15:0];
`else
    return w[31:16];
`endif
  endfunction

  function automatic logic [15:0] exp_r(input logic [31:0] w);
`ifdef PCM_VOLUME_EN
    return (w[15:0] == 16'h0) ? 16'h0 : 16'h0;
`else
    return w[15:0];
`endif
  endfunction

  task automatic push(input logic [31:0] w);
    fifo_mem[wr_ptr % 64] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] words [0:3];
  int rb, sb, found;

  initial begin
    words[0] = 32'h12345678;
    words[1] = 32'hA5A55A5A;
    words[2] = 32'h0001FFFF;
    words[3] = 32'h7FFF8001;

    reset = 1'b1; enable = 1'b0; rate_div = 16'd9; irq_thresh = 10'd0;
    irq_clear = 1'b0; underrun_clr = 1'b0;
    cycles(3);
    check("rst_rd_en",  {31'd0, fifo_rd_en}, 32'd0);
    check("rst_pcm_l",  {16'd0, pcm_l}, 32'd0);
    check("rst_pcm_r",  {16'd0, pcm_r}, 32'd0);
    check("rst_strobe", {31'd0, sample_strobe}, 32'd0);
    check("rst_irq",    {31'd0, irq_pending}, 32'd0);
    check("rst_urun",   {31'd0, underrun}, 32'd0);
    reset = 1'b0;
    cycles(2);

    // rate_div=9 with four preloaded words, then run dry.
    for (int i = 0; i < 4; i++) push(words[i]);
    rb = rd_q.size(); sb = st_cyc.size();
    enable = 1'b1;
    cycles(56);
    check("t2_rd_count", rd_q.size() - rb, 32'd4);
    if (rd_q.size() >= rb + 4 && st_cyc.size() >= sb + 5) begin
      for (int i = 0; i < 3; i++)
        check("t2_rd_period", rd_q[rb+i+1] - rd_q[rb+i], 32'd10);
      for (int i = 0; i < 4; i++) begin
        check("t2_out_lat", st_cyc[sb+i] - rd_q[rb+i], LAT);
        check("t2_pcm_l", {16'd0, st_l[sb+i]}, {16'd0, exp_l(words[i])});
        check("t2_pcm_r", {16'd0, st_r[sb+i]}, {16'd0, exp_r(words[i])});
        check("t2_no_urun", {31'd0, st_u[sb+i]}, 32'd0);
      end
      check("t2_urun_time", st_cyc[sb+4] - rd_q[rb+3], 32'd10);
      check("t2_urun_l", {16'd0, st_l[sb+4]}, 32'd0);
      check("t2_urun_r", {16'd0, st_r[sb+4]}, 32'd0);
      check("t2_urun_flag", {31'd0, st_u[sb+4]}, 32'd1);
    end else begin
      check("t2_events", 32'd0, 32'd1);
    end
    enable = 1'b0;
    cycles(3);
    check("t2_idle_l", {16'd0, pcm_l}, 32'd0);
    check("t2_urun_sticky", {31'd0, underrun}, 32'd1);
    underrun_clr = 1'b1;
    cycles(1);
    underrun_clr = 1'b0;
    check("t2_urun_clr", {31'd0, underrun}, 32'd0);

    // rate_div=1 clamps to the minimum period; nothing popped while empty.
    rate_div = 16'd1;
    rb = rd_q.size(); sb = st_cyc.size();
    enable = 1'b1;
    cycles(30);
    check("t4_no_pop", rd_q.size() - rb, 32'd0);
    check("t4_strobes", {31'd0, (st_cyc.size() >= sb + 5)}, 32'd1);
    if (st_cyc.size() >= sb + 3) begin
      check("t4_period_a", st_cyc[sb+1] - st_cyc[sb], MIN_PERIOD);
      check("t4_period_b", st_cyc[sb+2] - st_cyc[sb+1], MIN_PERIOD);
    end else begin
      check("t4_events", 32'd0, 32'd1);
    end
    check("t4_urun", {31'd0, underrun}, 32'd1);
    push(32'h11112222);
    push(32'h33334444);
    cycles(24);
    check("t4_pop_count", rd_q.size() - rb, 32'd2);
    if (rd_q.size() >= rb + 2)
      check("t4_pop_period", rd_q[rb+1] - rd_q[rb], MIN_PERIOD);
    else
      check("t4_pop_events", 32'd0, 32'd1);
    check("t4_b2b", b2b, 32'd0);
    enable = 1'b0;
    cycles(3);

    // Low-water IRQ: set on 17->15, set beats clear, clear works, thresh 0 inert.
    cnt_ovr_en = 1'b1; cnt_ovr = 10'd17; irq_thresh = 10'd16;
    irq_clear = 1'b1;
    cycles(1);
    irq_clear = 1'b0;
    check("t5_irq_init", {31'd0, irq_pending}, 32'd0);
    enable = 1'b1;
    cycles(2);
    check("t5_irq_17", {31'd0, irq_pending}, 32'd0);
    cnt_ovr = 10'd15;
    cycles(1);
    check("t5_irq_15", {31'd0, irq_pending}, 32'd1);
    irq_clear = 1'b1;
    cycles(1);
    irq_clear = 1'b0;
    check("t5_set_wins", {31'd0, irq_pending}, 32'd1);
    cnt_ovr = 10'd17;
    irq_clear = 1'b1;
    cycles(1);
    irq_clear = 1'b0;
    check("t5_irq_clr", {31'd0, irq_pending}, 32'd0);
    irq_thresh = 10'd0; cnt_ovr = 10'd0;
    cycles(2);
    check("t5_thresh0", {31'd0, irq_pending}, 32'd0);
    enable = 1'b0; cnt_ovr_en = 1'b0;
    underrun_clr = 1'b1;
    cycles(1);
    underrun_clr = 1'b0;
    cycles(3);

    // Enable drops during POP: word still delivered, then IDLE and silence.
    rate_div = 16'd4;
    push(32'h40001234);
    push(32'h0BAD0CAB);
    push(32'h13572468);
    rb = rd_q.size();
    enable = 1'b1;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (fifo_rd_en) found = 1;
    end
    check("t6_pop_seen", found, 32'd1);
    enable = 1'b0;
    cycles(LAT);
    check("t6_strobe", {31'd0, sample_strobe}, 32'd1);
    check("t6_pcm_l", {16'd0, pcm_l}, {16'd0, exp_l(32'h40001234)});
    check("t6_pcm_r", {16'd0, pcm_r}, {16'd0, exp_r(32'h40001234)});
    cycles(1);
    check("t6_cleared_l", {16'd0, pcm_l}, 32'd0);
    check("t6_cleared_r", {16'd0, pcm_r}, 32'd0);
    cycles(20);
    check("t6_one_pop", rd_q.size() - rb, 32'd1);
    check("t6_strobe_idle", {31'd0, sample_strobe}, 32'd0);
    check("bad_pop_total", bad_pop, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
